// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared widths, opcodes and FSM state type for the integer execution unit
package alu_exec_unit_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int OP_W  = 5;

    localparam logic [TAG_W-1:0] NO_TAG = '0;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR = 5'd4;
    localparam logic [OP_W-1:0] OP_SLT = 5'd5;
    localparam logic [OP_W-1:0] OP_SLL = 5'd6;
    localparam logic [OP_W-1:0] OP_SRL = 5'd7;
    localparam logic [OP_W-1:0] OP_SRA = 5'd8;
    localparam logic [OP_W-1:0] OP_MUL = 5'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DONE
    } exe_state_t;

endpackage

// File: rtl/alu_exec_unit_comb.sv
// rtl/alu_exec_unit_comb.sv - combinational datapath for the single-cycle integer ops
module alu_comb #(
    parameter int XLEN = alu_exec_unit_pkg::XLEN
) (
    input  logic [alu_exec_unit_pkg::OP_W-1:0] op,
    input  logic [XLEN-1:0]                    a,
    input  logic [XLEN-1:0]                    b,
    output logic [XLEN-1:0]                    result
);
    import alu_exec_unit_pkg::*;

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Unknown opcodes (and MUL, which is handled elsewhere) yield 0 so the tag still retires.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: result = a << shamt;
            OP_SRL: result = a >> shamt;
            OP_SRA: result = $signed(a) >>> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer execution unit holding its result until the CDB arbiter grants it
module alu_exec_unit #(
    parameter int XLEN       = alu_exec_unit_pkg::XLEN,
    parameter int TAG_W      = alu_exec_unit_pkg::TAG_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [alu_exec_unit_pkg::OP_W-1:0] in_op,
    input  logic [XLEN-1:0]                    in_a,
    input  logic [XLEN-1:0]                    in_b,
    input  logic [TAG_W-1:0]                   in_label,
    output logic                               exe_able,
    output logic                               cdb_req,
    input  logic                               cdb_grant,
    output logic [TAG_W-1:0]                   cdb_label,
    output logic [XLEN-1:0]                    cdb_data,
    output logic                               busy
);
    import alu_exec_unit_pkg::*;

    localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

    exe_state_t      state, state_next;
    logic [3:0]      mul_cnt;
    logic [XLEN-1:0] mul_a, mul_b;
    logic [XLEN-1:0] product;
    logic [XLEN-1:0] alu_result;
    logic            accept;
    logic            is_mul;
    logic            mul_last;

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (alu_result)
    );

    assign exe_able = (state == ST_IDLE) || ((state == ST_DONE) && cdb_grant);
    assign accept   = in_valid && exe_able;
    assign is_mul   = (in_op == OP_MUL);
    assign product  = mul_a * mul_b;
    // Product lands on the edge the counter reaches 0, so cdb_req rises MUL_CYCLES after accept.
    assign mul_last = (mul_cnt <= 4'd1);
    assign cdb_req  = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_IDLE;
            ST_MULT: if (mul_last) state_next = ST_DONE;
            ST_DONE: if (cdb_grant) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (accept) begin
            state_next = is_mul ? ST_MULT : ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mul_cnt   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            cdb_label <= '0;
            cdb_data  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cdb_label <= in_label;
                if (is_mul) begin
                    mul_a   <= in_a;
                    mul_b   <= in_b;
                    mul_cnt <= MUL_INIT;
                end else begin
                    cdb_data <= alu_result;
                end
            end else if (state == ST_MULT) begin
                mul_cnt <= mul_cnt - 4'd1;
                if (mul_last) begin
                    cdb_data <= product;
                end
            end
        end
    end

    label_nonzero: assert property (@(posedge clk) disable iff (rst) accept |-> (in_label != '0));

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_label;
    logic        exe_able, cdb_req, cdb_grant, busy;
    logic [4:0]  cdb_label;
    logic [31:0] cdb_data;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   bcast_cnt = 0;
    bit   rnd_grant = 1'b0;
    int   w;
    int   b0;

    alu_exec_unit #(.XLEN(32), .TAG_W(5), .MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_label  (in_label),
        .exe_able  (exe_able),
        .cdb_req   (cdb_req),
        .cdb_grant (cdb_grant),
        .cdb_label (cdb_label),
        .cdb_data  (cdb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'(int'(a) >>> b[4:0]);
            OP_MUL:  return 32'(longint'(a) * longint'(b));
            default: return 32'd0;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge with inputs still driven.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit push,
                         output int waited);
        in_op = op; in_a = a; in_b = b; in_label = tag; in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (exe_able) break;
            waited++;
            if (waited > 60) break;
            @(posedge clk); #1;
            if (rnd_grant) cdb_grant = 1'($urandom_range(0, 1));
        end
        if (waited > 60) check_eq("accept_timeout", 32'(exe_able), 32'd1);
        else if (push) sb.push_back('{tag: tag, data: exp});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && cdb_req && cdb_grant) begin
            bcast_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_bcast", 32'(cdb_label), 32'(NO_TAG));
            end else begin
                mon_e = sb.pop_front();
                check_eq("cdb_label", 32'(cdb_label), 32'(mon_e.tag));
                check_eq("cdb_data", cdb_data, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_label = '0; cdb_grant = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cdb_req", 32'(cdb_req), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_exe_able", 32'(exe_able), 32'd1);
        check_eq("rst_cdb_label", 32'(cdb_label), 32'd0);
        check_eq("rst_cdb_data", cdb_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset during MUL discards the in-flight op
        issue(OP_MUL, 32'd6, 32'd7, 5'd3, 32'd42, 1'b0, w);
        idle();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midmul_rst_cdb_req", 32'(cdb_req), 32'd0);
        check_eq("midmul_rst_busy", 32'(busy), 32'd0);
        check_eq("midmul_rst_exe_able", 32'(exe_able), 32'd1);
        cdb_grant = 1'b1;
        b0 = bcast_cnt;
        repeat (MC + 3) @(negedge clk);
        check_eq("midmul_no_bcast", 32'(bcast_cnt), 32'(b0));
        @(posedge clk); #1;

        // Single-cycle ADD with wraparound
        issue(OP_ADD, 32'd5, 32'hFFFF_FFFF, 5'd2, 32'd4, 1'b1, w);
        idle();
        @(negedge clk);
        check_eq("add_req", 32'(cdb_req), 32'd1);
        check_eq("add_label", 32'(cdb_label), 32'd2);
        check_eq("add_data", cdb_data, 32'd4);
        @(negedge clk);
        check_eq("add_req_drop", 32'(cdb_req), 32'd0);
        @(posedge clk); #1;

        // Back-to-back simple ops
        issue(OP_SUB, 32'd10, 32'd3, 5'd1, 32'd7, 1'b1, w);
        issue(OP_XOR, 32'hF0, 32'hFF, 5'd2, 32'h0F, 1'b1, w);
        check_eq("b2b_no_bubble", 32'(w), 32'd0);
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;

        // MUL latency and back-pressure
        issue(OP_MUL, 32'h1_0000, 32'h1_0000, 5'd4, 32'd0, 1'b1, w);
        idle();
        for (int k = 1; k < MC; k++) begin
            @(negedge clk);
            check_eq("mul_exe_able_low", 32'(exe_able), 32'd0);
            check_eq("mul_req_low", 32'(cdb_req), 32'd0);
        end
        @(negedge clk);
        check_eq("mul_req_at_latency", 32'(cdb_req), 32'd1);
        check_eq("mul_data", cdb_data, 32'd0);
        @(posedge clk); #1;

        // Grant stall holds result and blocks a pending op
        cdb_grant = 1'b0;
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1'b1, w);
        in_op = OP_ADD; in_a = 32'd1; in_b = 32'd2; in_label = 5'd7; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_req", 32'(cdb_req), 32'd1);
            check_eq("stall_label", 32'(cdb_label), 32'd5);
            check_eq("stall_data", cdb_data, 32'd1);
            check_eq("stall_exe_able", 32'(exe_able), 32'd0);
            @(posedge clk); #1;
        end
        cdb_grant = 1'b1;
        @(negedge clk);
        check_eq("grant_accept_same_cycle", 32'(exe_able), 32'd1);
        sb.push_back('{tag: 5'd7, data: 32'd3});
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_eq("pending_label", 32'(cdb_label), 32'd7);
        @(posedge clk); #1;

        // Shifts and undefined opcode
        issue(OP_SRA, 32'h8000_0000, 32'd4, 5'd8, 32'hF800_0000, 1'b1, w);
        issue(OP_SRL, 32'h8000_0000, 32'd4, 5'd9, 32'h0800_0000, 1'b1, w);
        issue(5'd31, 32'h1234, 32'h5678, 5'd6, 32'd0, 1'b1, w);
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;

        // Random mix with random grant
        rnd_grant = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = 5'($urandom_range(0, 10));
            if (op == 5'd10) op = 5'd20;
            a = $urandom();
            b = $urandom();
            issue(op, a, b, 5'($urandom_range(1, 31)), model(op, a, b), 1'b1, w);
            if (!rnd_grant) break;
            cdb_grant = 1'($urandom_range(0, 1));
        end
        rnd_grant = 1'b0;
        idle();
        cdb_grant = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        check_eq("drain_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
